// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, ROM fetch address and the IF/ID pipeline register.
// Define IF_PERF_CNT_EN to add the fetch/stall/flush performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o,
  input  logic [31:0] inst_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_inst_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_stall_o,
  output logic [31:0] perf_flush_o
`endif
);

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic        bubble;
  logic        load;

  assign pc_o     = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  // A redirect also squashes IF/ID: the word fetched this cycle is on the wrong path.
  assign bubble   = flush_i | redirect_i;
  assign load     = ~bubble & ~stall_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_i) begin
      pc_q <= {redirect_pc_i[31:2], 2'b00};
    end else if (!stall_i) begin
      pc_q <= pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      if_id_valid_o <= 1'b0;
      if_id_pc_o    <= 32'h0000_0000;
      if_id_pc4_o   <= 32'h0000_0000;
      if_id_inst_o  <= NOP_INST;
    end else if (load) begin
      if_id_valid_o <= 1'b1;
      if_id_pc_o    <= pc_q;
      if_id_pc4_o   <= pc_plus4;
      if_id_inst_o  <= inst_i;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_o <= 32'h0000_0000;
      perf_stall_o <= 32'h0000_0000;
      perf_flush_o <= 32'h0000_0000;
    end else begin
      if (load)                    perf_fetch_o <= perf_fetch_o + 32'd1;
      if (stall_i && !redirect_i)  perf_stall_o <= perf_stall_o + 32'd1;
      if (bubble)                  perf_flush_o <= perf_flush_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; a small ROM model answers pc_o combinationally.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o;
  logic [31:0] inst_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;
  logic [31:0] if_id_inst_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_o;
  logic [31:0] perf_stall_o;
  logic [31:0] perf_flush_o;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2008_0005 : (a ^ 32'hDEAD_0000);
  endfunction

  assign inst_i = rom(pc_o);

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_o          (pc_o),
    .inst_i        (inst_i),
    .if_id_valid_o (if_id_valid_o),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_pc4_o   (if_id_pc4_o),
    .if_id_inst_o  (if_id_inst_o)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_o  (perf_fetch_o),
    .perf_stall_o  (perf_stall_o),
    .perf_flush_o  (perf_flush_o)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    step(); step();
    total++; if (pc_o !== 32'h0) $display("FAIL rst_pc got=%h exp=%h", pc_o, 32'h0); else passed++;
    total++; if (if_id_valid_o !== 1'b0) $display("FAIL rst_valid got=%b exp=0", if_id_valid_o); else passed++;
    total++; if (if_id_pc_o !== 32'h0) $display("FAIL rst_ifpc got=%h exp=0", if_id_pc_o); else passed++;
    total++; if (if_id_pc4_o !== 32'h0) $display("FAIL rst_ifpc4 got=%h exp=0", if_id_pc4_o); else passed++;
    total++; if (if_id_inst_o !== 32'h0) $display("FAIL rst_inst got=%h exp=0", if_id_inst_o); else passed++;
`ifdef IF_PERF_CNT_EN
    total++; if ({perf_fetch_o, perf_stall_o, perf_flush_o} !== 96'h0) $display("FAIL rst_perf got=%h/%h/%h exp=0", perf_fetch_o, perf_stall_o, perf_flush_o); else passed++;
`endif
  endtask

  task automatic test_startup();
    rst_n = 1'b1;
    total++; if (pc_o !== 32'h0) $display("FAIL start_c0_pc got=%h exp=0", pc_o); else passed++;
    total++; if (if_id_valid_o !== 1'b0) $display("FAIL start_c0_valid got=%b exp=0", if_id_valid_o); else passed++;
    step();
    total++; if (pc_o !== 32'h4) $display("FAIL start_c1_pc got=%h exp=4", pc_o); else passed++;
    total++; if (if_id_valid_o !== 1'b1) $display("FAIL start_c1_valid got=%b exp=1", if_id_valid_o); else passed++;
    total++; if (if_id_inst_o !== 32'h2008_0005) $display("FAIL start_c1_inst got=%h exp=20080005", if_id_inst_o); else passed++;
    total++; if (if_id_pc_o !== 32'h0) $display("FAIL start_c1_ifpc got=%h exp=0", if_id_pc_o); else passed++;
    total++; if (if_id_pc4_o !== 32'h4) $display("FAIL start_c1_ifpc4 got=%h exp=4", if_id_pc4_o); else passed++;
  endtask

  task automatic test_stall();
    step(); step(); step();
    total++; if (pc_o !== 32'h10) $display("FAIL stall_pre_pc got=%h exp=10", pc_o); else passed++;
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (pc_o !== 32'h10) $display("FAIL stall_pc[%0d] got=%h exp=10", i, pc_o); else passed++;
      total++; if (if_id_pc_o !== 32'hC || if_id_pc4_o !== 32'h10 || if_id_valid_o !== 1'b1)
        $display("FAIL stall_ifid[%0d] got=%h/%h/%b exp=c/10/1", i, if_id_pc_o, if_id_pc4_o, if_id_valid_o); else passed++;
      total++; if (if_id_inst_o !== rom(32'hC)) $display("FAIL stall_inst[%0d] got=%h exp=%h", i, if_id_inst_o, rom(32'hC)); else passed++;
    end
    stall_i = 1'b0;
    step();
    total++; if (pc_o !== 32'h14) $display("FAIL stall_rel_pc got=%h exp=14", pc_o); else passed++;
    total++; if (if_id_pc_o !== 32'h10) $display("FAIL stall_rel_ifpc got=%h exp=10", if_id_pc_o); else passed++;
  endtask

  task automatic test_redirect_stall();
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0042;
    step();
    total++; if (pc_o !== 32'h40) $display("FAIL redir_pc got=%h exp=40", pc_o); else passed++;
    total++; if (if_id_valid_o !== 1'b0) $display("FAIL redir_valid got=%b exp=0", if_id_valid_o); else passed++;
    total++; if (if_id_inst_o !== 32'h0 || if_id_pc_o !== 32'h0 || if_id_pc4_o !== 32'h0)
      $display("FAIL redir_bubble got=%h/%h/%h exp=0/0/0", if_id_inst_o, if_id_pc_o, if_id_pc4_o); else passed++;
    stall_i = 1'b0; redirect_i = 1'b0;
    step();
    total++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h40) $display("FAIL redir_next got=%b/%h exp=1/40", if_id_valid_o, if_id_pc_o); else passed++;
    total++; if (if_id_inst_o !== rom(32'h40)) $display("FAIL redir_next_inst got=%h exp=%h", if_id_inst_o, rom(32'h40)); else passed++;
    total++; if (pc_o !== 32'h44) $display("FAIL redir_next_pc got=%h exp=44", pc_o); else passed++;
  endtask

  task automatic test_flush();
    redirect_i = 1'b1; redirect_pc_i = 32'h1C;
    step();
    redirect_i = 1'b0;
    step();
    total++; if (pc_o !== 32'h20 || if_id_valid_o !== 1'b1) $display("FAIL flush_pre got=%h/%b exp=20/1", pc_o, if_id_valid_o); else passed++;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    total++; if (pc_o !== 32'h24) $display("FAIL flush_pc got=%h exp=24", pc_o); else passed++;
    total++; if (if_id_valid_o !== 1'b0 || if_id_inst_o !== 32'h0) $display("FAIL flush_bubble got=%b/%h exp=0/0", if_id_valid_o, if_id_inst_o); else passed++;
    total++; if (if_id_pc_o !== 32'h0 || if_id_pc4_o !== 32'h0) $display("FAIL flush_ifpc got=%h/%h exp=0/0", if_id_pc_o, if_id_pc4_o); else passed++;
    step();
    total++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h24) $display("FAIL flush_after got=%b/%h exp=1/24", if_id_valid_o, if_id_pc_o); else passed++;
  endtask

  task automatic test_stall_flush();
    stall_i = 1'b1; flush_i = 1'b1;
    step();
    stall_i = 1'b0; flush_i = 1'b0;
    total++; if (pc_o !== 32'h28) $display("FAIL stfl_pc got=%h exp=28", pc_o); else passed++;
    total++; if (if_id_valid_o !== 1'b0) $display("FAIL stfl_valid got=%b exp=0", if_id_valid_o); else passed++;
    step();
    total++; if (pc_o !== 32'h2C || if_id_pc_o !== 32'h28) $display("FAIL stfl_after got=%h/%h exp=2c/28", pc_o, if_id_pc_o); else passed++;
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
    step();
    redirect_i = 1'b0;
    total++; if (pc_o !== 32'hFFFF_FFFC) $display("FAIL wrap_align got=%h exp=fffffffc", pc_o); else passed++;
    step();
    total++; if (pc_o !== 32'h0) $display("FAIL wrap_pc got=%h exp=0", pc_o); else passed++;
    total++; if (if_id_pc_o !== 32'hFFFF_FFFC) $display("FAIL wrap_ifpc got=%h exp=fffffffc", if_id_pc_o); else passed++;
    total++; if (if_id_pc4_o !== 32'h0) $display("FAIL wrap_ifpc4 got=%h exp=0", if_id_pc4_o); else passed++;
    total++; if (if_id_inst_o !== rom(32'hFFFF_FFFC)) $display("FAIL wrap_inst got=%h exp=%h", if_id_inst_o, rom(32'hFFFF_FFFC)); else passed++;
  endtask

  task automatic test_reset_midstream();
    redirect_i = 1'b1; redirect_pc_i = 32'h7C;
    step();
    redirect_i = 1'b0;
    step();
    total++; if (pc_o !== 32'h80 || if_id_valid_o !== 1'b1) $display("FAIL mrst_pre got=%h/%b exp=80/1", pc_o, if_id_valid_o); else passed++;
    rst_n = 1'b0; stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h100;
    step();
    total++; if (pc_o !== 32'h0) $display("FAIL mrst_pc got=%h exp=0", pc_o); else passed++;
    total++; if (if_id_valid_o !== 1'b0 || if_id_pc_o !== 32'h0 || if_id_inst_o !== 32'h0)
      $display("FAIL mrst_ifid got=%b/%h/%h exp=0/0/0", if_id_valid_o, if_id_pc_o, if_id_inst_o); else passed++;
`ifdef IF_PERF_CNT_EN
    total++; if ({perf_fetch_o, perf_stall_o, perf_flush_o} !== 96'h0) $display("FAIL mrst_perf got=%h/%h/%h exp=0", perf_fetch_o, perf_stall_o, perf_flush_o); else passed++;
`endif
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    rst_n = 1'b1;
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    step(); step(); step();
    stall_i = 1'b1;
    step(); step();
    stall_i = 1'b0; flush_i = 1'b1;
    step();
    flush_i = 1'b0; stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200;
    step();
    stall_i = 1'b0; redirect_i = 1'b0;
    total++; if (perf_fetch_o !== 32'd3) $display("FAIL perf_fetch got=%0d exp=3", perf_fetch_o); else passed++;
    total++; if (perf_stall_o !== 32'd2) $display("FAIL perf_stall got=%0d exp=2", perf_stall_o); else passed++;
    total++; if (perf_flush_o !== 32'd2) $display("FAIL perf_flush got=%0d exp=2", perf_flush_o); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_redirect_stall();
    test_flush();
    test_stall_flush();
    test_wrap();
    test_reset_midstream();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline; sits directly upstream of the instruction ROM and feeds the decode stage.
- Owns the PC register and drives the fetch address to the ROM, which returns the instruction combinationally in the same cycle.
- Holds the IF/ID pipeline register (valid, PC, PC+4, instruction).
- Honours hazard-unit stalls, branch/jump redirects and pipeline flushes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word injected into IF/ID on flush/reset (MIPS sll $0,$0,0).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
- stall_i  input  1  hazard unit: hold PC and IF/ID contents.
- flush_i  input  1  squash IF/ID contents (insert bubble).
- redirect_i  input  1  taken branch/jump resolved downstream; load redirect_pc_i.
- redirect_pc_i  input  32  redirect target byte address.
- pc_o  output  32  current fetch address to the instruction ROM (equals pc_q).
- inst_i  input  32  instruction word returned by the ROM for pc_o, same cycle.
- if_id_valid_o  output  1  IF/ID holds a real instruction.
- if_id_pc_o  output  32  PC of the instruction in IF/ID.
- if_id_pc4_o  output  32  that PC + 4.
- if_id_inst_o  output  32  instruction in IF/ID.

Behaviour:
- Reset (rst_n=0 at posedge) sets:
  - pc_q = RESET_PC
  - if_id_valid_o = 0
  - if_id_pc_o = 0
  - if_id_pc4_o = 0
  - if_id_inst_o = NOP_INST
- Reset has priority over every other input.
- pc_o = pc_q, driven combinationally. No other output has a combinational path from an input.
- PC update, in priority order:
  - redirect_i=1: pc_q <= {redirect_pc_i[31:2], 2'b00}. Low two bits are forced to zero. Redirect overrides stall_i so a resolved branch is never lost.
  - stall_i=1: pc_q holds.
  - otherwise: pc_q <= pc_q + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
- IF/ID update, in priority order:
  - flush_i=1 or redirect_i=1: valid <= 0, inst <= NOP_INST, pc/pc4 <= 0.
  - stall_i=1: all IF/ID fields hold.
  - otherwise: valid <= 1, inst <= inst_i, pc <= pc_q, pc4 <= pc_q + 4 (same wrap rule).
- Latency: an instruction fetched at cycle N appears in IF/ID at cycle N+1.
- Startup: first posedge after rst_n rises captures the RESET_PC instruction; IF/ID is invalid until then.
- stall_i and flush_i together: IF/ID is bubbled; PC holds unless redirect_i is also set.
- Redirect during stall: PC takes the target and IF/ID is bubbled, so no stale instruction escapes.
- Reset asserted mid-stream: state is discarded at that posedge; nothing in flight survives.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, three 32-bit output ports are added, all reset to 0, all wrapping modulo 2^32, updated on posedge while rst_n=1:
  - perf_fetch_o: counts cycles where IF/ID loads a valid instruction.
  - perf_stall_o: counts cycles with stall_i=1 and redirect_i=0.
  - perf_flush_o: counts cycles with flush_i=1 or redirect_i=1.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, ROM word0=0x2008_0005, no stall/flush:
  - Cycle 0: pc_o=0.
  - Cycle 1: pc_o=4, if_id_valid=1, if_id_inst=0x2008_0005, if_id_pc=0, if_id_pc4=4.
- stall_i high for 3 cycles at pc_q=0x10:
  - pc_o stays 0x10 and all IF/ID fields hold for 3 cycles.
  - Cycle after release: pc_o=0x14.
- redirect_i=1, redirect_pc_i=0x0000_0042, while stall_i=1:
  - Next cycle: pc_o=0x40, if_id_valid=0, if_id_inst=0.
  - Following cycle: IF/ID holds the instruction at 0x40.
- flush_i=1 alone at pc_q=0x20:
  - pc_o=0x24, IF/ID bubbled (valid=0, inst=NOP_INST).
- Wrap check, pc_q=0xFFFF_FFFC, no stall:
  - Next cycle: pc_o=0x0000_0000, if_id_pc=0xFFFF_FFFC, if_id_pc4=0x0000_0000.
- rst_n driven low mid-stream at pc_q=0x80 with IF/ID valid:
  - Next posedge: pc_o=RESET_PC, valid=0.
  - With IF_PERF_CNT_EN defined, all three counters read 0.
